sort_sequencer: RTL and testbench

Sequential sorting engine that time-shares a single WIDTH-bit magnitude comparator across a batch of DEPTH buffered values. It accepts a fixed-size batch over a valid/ready input stream and sorts it in place with one comparison per cycle (bubble sort, early exit). It then streams the sorted batch out over a valid/ready output stream. It sits between a producer of unordered samples and any consumer needing ranked data (median/min/max selection).

---
 rtl/sort_sequencer_pkg.sv | 17 +
 rtl/sort_sequencer_cmp.sv | 16 +
 rtl/sort_sequencer.sv | 132 +++++++++++++
 tb/tb_sort_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_sequencer_pkg.sv
// Shared types and helpers for the sort_sequencer batch sorter.
package sort_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int SWAP_CNT_W = 16;

    // Swap counter holds at all-ones rather than wrapping.
    function automatic logic [SWAP_CNT_W-1:0] sat_inc(input logic [SWAP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sort_sequencer_cmp.sv
// Unsigned magnitude comparator shared by every compare slot of the sorter.
module byte_order_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt,
    output logic             b_gt,
    output logic             eq
);

    assign a_gt = (a > b);
    assign b_gt = (b > a);
    assign eq   = (a == b);

endmodule

// File: rtl/sort_sequencer.sv
// Buffers a DEPTH-element batch, bubble-sorts it in place with one shared
// comparator (one compare per cycle, early exit), then streams it out.
module sort_sequencer
    import sort_sequencer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter bit ASCEND = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [SWAP_CNT_W-1:0] swap_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(DEPTH - 2);

    state_e                  state_q;
    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W-1:0]        idx_q;
    logic                    pass_swapped_q;
    logic [SWAP_CNT_W-1:0]   swap_count_q;

    logic [PTR_W-1:0]        idx_nxt;
    logic [WIDTH-1:0]        cmp_a;
    logic [WIDTH-1:0]        cmp_b;
    logic                    a_gt;
    logic                    b_gt;
    logic                    eq;
    logic                    out_of_order;

    assign idx_nxt = idx_q + PTR_ONE;
    assign cmp_a   = mem_q[idx_q];
    assign cmp_b   = mem_q[idx_nxt];

    byte_order_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a    (cmp_a),
        .b    (cmp_b),
        .a_gt (a_gt),
        .b_gt (b_gt),
        .eq   (eq)
    );

    // Equal keys never swap, which keeps the sort stable.
    assign out_of_order = !eq && (ASCEND ? a_gt : b_gt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_LOAD;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            idx_q          <= '0;
            pass_swapped_q <= 1'b0;
            swap_count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_valid) begin
                        mem_q[wr_ptr_q] <= in_data;
                        if (wr_ptr_q == '0) begin
                            swap_count_q <= '0;
                        end
                        if (wr_ptr_q == PTR_LAST) begin
                            state_q        <= ST_SORT;
                            wr_ptr_q       <= '0;
                            idx_q          <= '0;
                            pass_swapped_q <= 1'b0;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + PTR_ONE;
                        end
                    end
                end
                ST_SORT: begin
                    if (out_of_order) begin
                        mem_q[idx_q]   <= cmp_b;
                        mem_q[idx_nxt] <= cmp_a;
                        pass_swapped_q <= 1'b1;
                        swap_count_q   <= sat_inc(swap_count_q);
                    end
                    // A pass with no swaps, including its final compare, ends the sort.
                    if (idx_q == IDX_LAST) begin
                        if (!pass_swapped_q && !out_of_order) begin
                            state_q  <= ST_DRAIN;
                            rd_ptr_q <= '0;
                        end else begin
                            idx_q          <= '0;
                            pass_swapped_q <= 1'b0;
                        end
                    end else begin
                        idx_q <= idx_nxt;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (rd_ptr_q == PTR_LAST) begin
                            state_q  <= ST_LOAD;
                            rd_ptr_q <= '0;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + PTR_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_DRAIN);
    assign out_last   = (state_q == ST_DRAIN) && (rd_ptr_q == PTR_LAST);
    assign busy       = (state_q != ST_LOAD);
    assign out_data   = mem_q[rd_ptr_q];
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Randomized self-checking bench: an ascending and a descending instance
// checked against a rank/inversion based reference model.
module tb_sort_sequencer;

    localparam int W = 8;
    localparam int D = 8;

    typedef logic [W-1:0] batch_t [D];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid   [2];
    logic         in_ready   [2];
    logic [W-1:0] in_data    [2];
    logic         out_valid  [2];
    logic         out_ready  [2];
    logic [W-1:0] out_data   [2];
    logic         out_last   [2];
    logic         busy       [2];
    logic [15:0]  swap_count [2];

    int n_tests = 0;
    int n_fail  = 0;
    int prev_swaps [2];

    always #5 clk = ~clk;

    sort_sequencer #(.WIDTH(W), .DEPTH(D), .ASCEND(1'b1)) u_asc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .busy(busy[0]), .swap_count(swap_count[0])
    );

    sort_sequencer #(.WIDTH(W), .DEPTH(D), .ASCEND(1'b0)) u_desc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .busy(busy[1]), .swap_count(swap_count[1])
    );

    // x must end up after y in the output order
    function automatic bit goes_after(input logic [W-1:0] x, input logic [W-1:0] y, input bit asc);
        return asc ? (x > y) : (x < y);
    endfunction

    // Expected order by stable ranking; swaps = inversions; passes = 1 + the
    // largest count of misplaced predecessors any single element has.
    function automatic void model(input batch_t v, input bit asc, output batch_t s,
                                  output int inv, output int passes);
        int maxd;
        maxd = 0;
        inv  = 0;
        for (int j = 0; j < D; j++) begin
            int cnt;
            int rank;
            cnt  = 0;
            rank = 0;
            for (int i = 0; i < D; i++) begin
                if (i < j && goes_after(v[i], v[j], asc)) cnt++;
                if (goes_after(v[j], v[i], asc)) rank++;
                if (i < j && v[i] == v[j]) rank++;
            end
            inv += cnt;
            if (cnt > maxd) maxd = cnt;
            s[rank] = v[j];
        end
        passes = maxd + 1;
    endfunction

    task automatic run_batch(input int d, input batch_t v, input bit gaps, input bit bp,
                             input bit b2b, input logic [W-1:0] nxt0, input int abort_at);
        batch_t exp;
        int inv, passes, k, cyc, phase, i;
        bit seen_first, stalled, rdy, vld;
        logic [W-1:0] held;
        model(v, (d == 0), exp, inv, passes);
        k = 0;
        seen_first = 0;
        while (k < D) begin
            vld = gaps ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            n_tests++;
            if (in_ready[d] !== 1'b1) begin
                n_fail++; $display("FAIL load_in_ready dut%0d: got %b expected 1", d, in_ready[d]);
            end
            if (k == 0) begin
                n_tests++;
                if (swap_count[d] !== 16'(prev_swaps[d])) begin
                    n_fail++; $display("FAIL swap_hold dut%0d: got %0d expected %0d", d, swap_count[d], prev_swaps[d]);
                end
            end
            if (k == 1 && !seen_first) begin
                seen_first = 1;
                n_tests++;
                if (swap_count[d] !== 16'd0) begin
                    n_fail++; $display("FAIL swap_clear dut%0d: got %0d expected 0", d, swap_count[d]);
                end
            end
            in_valid[d] = vld;
            in_data[d]  = vld ? v[k] : W'($urandom);
            @(negedge clk);
            if (vld) k++;
        end
        n_tests++;
        if (busy[d] !== 1'b1 || in_ready[d] !== 1'b0) begin
            n_fail++; $display("FAIL sort_flags dut%0d: got busy=%b in_ready=%b expected 1/0", d, busy[d], in_ready[d]);
        end
        cyc = 0;
        while (out_valid[d] !== 1'b1 && cyc < 400) begin
            if (abort_at > 0 && cyc == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                n_tests++;
                if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_data[d] !== '0 ||
                    out_last[d] !== 1'b0 || busy[d] !== 1'b0 || swap_count[d] !== 16'd0) begin
                    n_fail++;
                    $display("FAIL async_reset dut%0d: got rdy=%b vld=%b data=%0d last=%b busy=%b swaps=%0d expected 1/0/0/0/0/0",
                             d, in_ready[d], out_valid[d], out_data[d], out_last[d], busy[d], swap_count[d]);
                end
                in_valid[0] = 0; in_valid[1] = 0;
                @(negedge clk);
                rst_n = 1'b1;
                prev_swaps[0] = 0; prev_swaps[1] = 0;
                $display("[TB] dut%0d batch aborted by reset after %0d sort cycles", d, cyc);
                return;
            end
            in_valid[d] = 1'($urandom_range(0, 1));
            in_data[d]  = W'($urandom);
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc != passes * (D - 1)) begin
            n_fail++; $display("FAIL sort_latency dut%0d: got %0d cycles expected %0d", d, cyc, passes * (D - 1));
            if (cyc >= 400) begin
                in_valid[d] = 0;
                return;
            end
        end
        n_tests++;
        if (swap_count[d] !== 16'(inv)) begin
            n_fail++; $display("FAIL swap_count dut%0d: got %0d expected %0d", d, swap_count[d], inv);
        end
        i = 0; phase = 0; stalled = 0; held = '0;
        while (i < D) begin
            n_tests++;
            if (out_valid[d] !== 1'b1 || out_data[d] !== exp[i] || out_last[d] !== (i == D - 1) || in_ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL drain[%0d] dut%0d: got vld=%b data=%0d last=%b rdy=%b expected 1/%0d/%b/0",
                         i, d, out_valid[d], out_data[d], out_last[d], in_ready[d], exp[i], (i == D - 1));
            end
            if (stalled) begin
                n_tests++;
                if (out_data[d] !== held) begin
                    n_fail++; $display("FAIL stall_hold dut%0d: got %0d expected %0d", d, out_data[d], held);
                end
            end
            rdy = bp ? (phase % 3 == 0) : 1'b1;
            phase++;
            out_ready[d] = rdy;
            in_valid[d]  = b2b ? 1'b1 : (bp ? 1'($urandom_range(0, 1)) : 1'b0);
            in_data[d]   = b2b ? nxt0 : W'($urandom);
            held    = out_data[d];
            stalled = !rdy;
            @(negedge clk);
            if (rdy) i++;
        end
        out_ready[d] = 1'b0;
        if (!b2b) in_valid[d] = 1'b0;
        n_tests++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
            n_fail++; $display("FAIL post_drain dut%0d: got vld=%b rdy=%b busy=%b expected 0/1/0", d, out_valid[d], in_ready[d], busy[d]);
        end
        prev_swaps[d] = inv;
        $display("[TB] dut%0d batch done: swaps=%0d passes=%0d latency=%0d", d, inv, passes, cyc);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_data[d] !== '0 ||
                out_last[d] !== 1'b0 || busy[d] !== 1'b0 || swap_count[d] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: got rdy=%b vld=%b data=%0d last=%b busy=%b swaps=%0d expected 1/0/0/0/0/0",
                         d, in_ready[d], out_valid[d], out_data[d], out_last[d], busy[d], swap_count[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset released");
    endtask

    task automatic test_reverse;
        batch_t v;
        for (int k = 0; k < D; k++) v[k] = W'(D - k);
        run_batch(0, v, 0, 0, 0, '0, 0);
    endtask

    task automatic test_sorted;
        batch_t v;
        for (int k = 0; k < D; k++) v[k] = W'(k + 1);
        run_batch(0, v, 0, 0, 0, '0, 0);
    endtask

    task automatic test_duplicates;
        batch_t v;
        v = '{8'd3, 8'd9, 8'd3, 8'd0, 8'd9, 8'd1, 8'd1, 8'd255};
        run_batch(1, v, 0, 0, 0, '0, 0);
    endtask

    task automatic test_backpressure;
        batch_t v;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < D; k++) v[k] = W'($urandom_range(0, 15));
            run_batch(r, v, 1, 1, 0, '0, 0);
        end
    endtask

    task automatic test_reset_mid_sort;
        batch_t v;
        for (int k = 0; k < D; k++) v[k] = W'(D - k);
        run_batch(0, v, 0, 0, 0, '0, 20);
        v = '{8'd5, 8'd1, 8'd4, 8'd2, 8'd3, 8'd8, 8'd7, 8'd6};
        run_batch(0, v, 0, 0, 0, '0, 0);
    endtask

    task automatic test_back_to_back;
        batch_t a;
        batch_t b;
        for (int k = 0; k < D; k++) begin
            a[k] = W'(D - k);
            b[k] = W'($urandom);
        end
        run_batch(0, a, 0, 0, 1, b[0], 0);
        run_batch(0, b, 0, 0, 0, '0, 0);
    endtask

    task automatic test_random;
        batch_t v;
        int d;
        for (int r = 0; r < 8; r++) begin
            d = $urandom_range(0, 1);
            for (int k = 0; k < D; k++) v[k] = (r % 2 == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
            run_batch(d, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, '0, 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 0; in_data[d] = '0; out_ready[d] = 0; prev_swaps[d] = 0;
        end
        test_reset();
        test_reverse();
        test_sorted();
        test_duplicates();
        test_backpressure();
        test_reset_mid_sort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
